add_12_reduce_ctrl: RTL and testbench

- Scheduler that reduces a job of LEN 12-bit floats (1 sign, 5 exp, 6 man) to a single sum.
- It uses one shared, fully pipelined 12-bit float adder (latency ADD_LAT, one issue per cycle).
- It sits between a vector producer (e.g. neuron product stream) and the activation stage.
- It keeps the adder pipeline busy by recirculating partial sums instead of stalling on latency.

---
 rtl/add_12_reduce_ctrl.sv | 132 +++++++++++++
 tb/tb_add_12_reduce_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_12_reduce_ctrl.sv
// Reduction scheduler: sums a job of LEN 12-bit floats through one shared, fully
// pipelined adder by recirculating partial sums so the pipeline never stalls on latency.
module add_12_reduce_ctrl #(
   parameter int ADD_LAT = 5,
   parameter int LEN_W   = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             in_valid_i,
   input  logic [11:0]      in_data_i,
   output logic             in_ready_o,
   output logic [11:0]      add_a_o,
   output logic [11:0]      add_b_o,
   input  logic [11:0]      add_sum_i,
   output logic             out_valid_o,
   output logic [11:0]      out_data_o,
   input  logic             out_ready_i,
   output logic             busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   remaining_q;
   logic [ADD_LAT-1:0] tag_q;
   logic               hold_v_q;
   logic [11:0]        hold_q;

   logic               sum_valid;
   logic               accept;
   logic               acc_done;
   logic               issue;
   logic               hold_load;
   logic               hold_clr;
   logic [11:0]        hold_d;

   assign sum_valid   = tag_q[ADD_LAT-1];
   assign in_ready_o  = (state_q == S_ACCUM) && (remaining_q != '0);
   assign accept      = in_valid_i & in_ready_o;
   // Exactly one live value is left once nothing remains to accept and nothing is in flight.
   assign acc_done    = (state_q == S_ACCUM) && (remaining_q == '0) && (tag_q == '0) && hold_v_q;
   assign busy_o      = (state_q != S_IDLE);
   assign out_valid_o = (state_q == S_OUT) ? 1'b1 : 1'b0;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values
   // regardless of the order in which the always blocks are evaluated.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_i) state_d = (len_i == '0) ? S_OUT : S_ACCUM;
         S_ACCUM: if (acc_done) state_d = S_OUT;
         S_OUT:   if (out_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      issue     = 1'b0;
      hold_load = 1'b0;
      hold_clr  = 1'b0;
      hold_d    = in_data_i;
      add_a_o   = 12'h000;
      add_b_o   = 12'h000;
      if (state_q == S_ACCUM) begin
         if (sum_valid && accept) begin
            issue   = 1'b1;
            add_a_o = add_sum_i;
            add_b_o = in_data_i;
         end else if (sum_valid && hold_v_q) begin
            issue    = 1'b1;
            hold_clr = 1'b1;
            add_a_o  = add_sum_i;
            add_b_o  = hold_q;
         end else if (sum_valid) begin
            hold_load = 1'b1;
            hold_d    = add_sum_i;
         end else if (accept && hold_v_q) begin
            issue    = 1'b1;
            hold_clr = 1'b1;
            add_a_o  = hold_q;
            add_b_o  = in_data_i;
         end else if (accept) begin
            hold_load = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         remaining_q <= '0;
         tag_q       <= '0;
         hold_v_q    <= 1'b0;
         out_data_o  <= 12'h000;
      end else begin
         tag_q <= (tag_q << 1) | ADD_LAT'(issue);
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  remaining_q <= len_i;
                  out_data_o  <= 12'h000;
               end
            end
            S_ACCUM: begin
               if (accept) remaining_q <= remaining_q - LEN_W'(1);
               if (acc_done) begin
                  out_data_o <= hold_q;
                  hold_v_q   <= 1'b0;
               end else if (hold_load) begin
                  hold_v_q <= 1'b1;
               end else if (hold_clr) begin
                  hold_v_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: hold data is not reset; hold_v_q qualifies it, so only the valid bit needs one.
   always_ff @(posedge clk_i) begin
      if (hold_load) hold_q <= hold_d;
   end

endmodule

// File: tb/tb_add_12_reduce_ctrl.sv
// Directed bench for add_12_reduce_ctrl: a bench-side float adder pipeline feeds add_sum_i,
// and a job-level model (element count, real-valued sum) is compared every cycle.
module tb_add_12_reduce_ctrl;

   localparam int ADD_LAT = 5;
   localparam int LEN_W   = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic [11:0]      in_data;
   logic             in_ready_o;
   logic [11:0]      add_a_o;
   logic [11:0]      add_b_o;
   logic [11:0]      add_sum;
   logic             out_valid_o;
   logic [11:0]      out_data_o;
   logic             out_ready;
   logic             busy_o;

   always #5 clk = ~clk;

   add_12_reduce_ctrl #(.ADD_LAT(ADD_LAT), .LEN_W(LEN_W)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .start_i    (start),
      .len_i      (len),
      .in_valid_i (in_valid),
      .in_data_i  (in_data),
      .in_ready_o (in_ready_o),
      .add_a_o    (add_a_o),
      .add_b_o    (add_b_o),
      .add_sum_i  (add_sum),
      .out_valid_o(out_valid_o),
      .out_data_o (out_data_o),
      .out_ready_i(out_ready),
      .busy_o     (busy_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic real fp_to_real(logic [11:0] f);
      real m;
      int  e;
      if (f[10:6] == 5'd0) return 0.0;
      m = 1.0 + f[5:0] / 64.0;
      e = int'(f[10:6]) - 15;
      if (e > 0) repeat (e) m = m * 2.0;
      else       repeat (-e) m = m / 2.0;
      return f[11] ? -m : m;
   endfunction

   function automatic logic [11:0] real_to_fp(real v);
      logic s;
      real  a;
      int   e;
      if (v == 0.0) return 12'h000;
      s = (v < 0.0);
      a = s ? -v : v;
      e = 15;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      return {s, 5'(e), 6'($rtoi((a - 1.0) * 64.0))};
   endfunction

   // Bench float adder: fixed latency, junk on add_sum when its slot holds no issue.
   logic [11:0] pd [ADD_LAT];
   logic        pv [ADD_LAT];
   always @(posedge clk) begin
      pd[0] <= real_to_fp(fp_to_real(add_a_o) + fp_to_real(add_b_o));
      pv[0] <= ((add_a_o | add_b_o) != 12'h000);
      for (int i = 1; i < ADD_LAT; i++) begin
         pd[i] <= pd[i-1];
         pv[i] <= pv[i-1];
      end
   end
   assign add_sum = pv[ADD_LAT-1] ? pd[ADD_LAT-1] : 12'h5A5;

   // Job-level model, advanced on each rising edge from the handshakes.
   int          cyc = 0;
   bit          m_init = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_ov_seen = 1'b0;
   int          m_len = 0;
   int          m_acc = 0;
   int          m_issues = 0;
   real         m_sum = 0.0;
   int          acc0_cyc = 0;
   int          start_cyc = 0;
   int          ov_cyc = 0;
   int          jobs_done = 0;
   int          last_issues = 0;
   logic [11:0] last_result = 12'h000;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_init    = 1'b1;
         m_busy    = 1'b0;
         m_ov_seen = 1'b0;
         m_acc     = 0;
         m_issues  = 0;
         m_sum     = 0.0;
      end else begin
         if (m_busy && ((add_a_o | add_b_o) != 12'h000)) m_issues++;
         if (in_valid && in_ready_o) begin
            if (m_acc == 0) acc0_cyc = cyc;
            m_acc++;
            m_sum = m_sum + fp_to_real(in_data);
         end
         if (out_valid_o && !m_ov_seen) begin
            m_ov_seen = 1'b1;
            ov_cyc    = cyc;
         end
         if (out_valid_o && out_ready) begin
            last_result = out_data_o;
            last_issues = m_issues;
            m_busy      = 1'b0;
            m_ov_seen   = 1'b0;
            jobs_done++;
         end else if (!m_busy && start) begin
            m_busy    = 1'b1;
            m_len     = int'(len);
            m_acc     = 0;
            m_sum     = 0.0;
            m_issues  = 0;
            start_cyc = cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("busy", busy_o, m_busy);
         check("in_ready", in_ready_o, m_busy && (m_acc < m_len));
         if (!m_busy) begin
            check("out_valid_idle", out_valid_o, 1'b0);
            check("add_a_idle", add_a_o, 12'h000);
            check("add_b_idle", add_b_o, 12'h000);
         end
         if (out_valid_o) begin
            check("out_data", out_data_o, real_to_fp(m_sum));
            check("all_accepted", m_acc, m_len);
         end
         if (m_ov_seen) check("out_valid_hold", out_valid_o, 1'b1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(int l);
      start = 1'b1;
      len   = LEN_W'(l);
      tick();
      start = 1'b0;
   endtask

   task automatic send(logic [11:0] d, int gap);
      int b = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready_o && b < 100) begin tick(); b++; end
      if (b >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: actual=no_ready required=ready");
      end
      tick();
      in_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic finish_job(string name, int l, logic [11:0] exp, int hold_cycles,
                             bit pulse_start, int lat_lo, int lat_hi);
      int b  = 0;
      int jd = jobs_done;
      int lat;
      while (!out_valid_o && b < 200) begin tick(); b++; end
      if (b >= 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: actual=no_out_valid required=out_valid", name);
         return;
      end
      for (int i = 0; i < hold_cycles; i++) begin
         if (pulse_start && i == 2) begin start = 1'b1; len = LEN_W'(3); end
         tick();
         start = 1'b0;
      end
      out_ready = 1'b1;
      b = 0;
      while (jobs_done == jd && b < 50) begin tick(); b++; end
      out_ready = 1'b0;
      check({name, "_handshake"}, jobs_done, jd + 1);
      check({name, "_result"}, last_result, exp);
      check({name, "_issues"}, last_issues, (l == 0) ? 0 : l - 1);
      check({name, "_busy_after"}, busy_o, 1'b0);
      lat = ov_cyc - ((l == 0) ? start_cyc : acc0_cyc);
      check({name, "_latency_ok"}, (lat >= lat_lo) && (lat <= lat_hi), 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
      in_data = 12'h000; out_ready = 1'b0;
      repeat (8) tick();
      check("rst_busy", busy_o, 1'b0);
      check("rst_in_ready", in_ready_o, 1'b0);
      check("rst_out_valid", out_valid_o, 1'b0);
      check("rst_out_data", out_data_o, 12'h000);
      check("rst_add_a", add_a_o, 12'h000);
      check("rst_add_b", add_b_o, 12'h000);
      rst_n = 1'b1;
      tick();

      // len=1: result exactly two cycles after the accept
      start_job(1);
      send(12'h3C0, 0);
      finish_job("len1", 1, 12'h3C0, 0, 1'b0, 2, 2);

      // len=4 back-to-back with out_ready tied high: 4.0
      out_ready = 1'b1;
      start_job(4);
      for (int i = 0; i < 4; i++) send(12'h3C0, 0);
      finish_job("len4", 4, 12'h440, 0, 1'b0, 0, 4 + ADD_LAT * 2 + 2);

      // len=3 with one idle cycle between elements: 3.0
      start_job(3);
      for (int i = 0; i < 3; i++) send(12'h3C0, 1);
      finish_job("len3_gaps", 3, 12'h420, 0, 1'b0, 0, 1000);

      // 1.0 + -1.0 = 0
      start_job(2);
      send(12'h3C0, 0);
      send(12'hBC0, 0);
      finish_job("len2_cancel", 2, 12'h000, 0, 1'b0, 0, 1000);

      // len=0: result one cycle after start, no adder issue
      start_job(0);
      finish_job("len0", 0, 12'h000, 0, 1'b0, 1, 1);

      // len=8, stray start pulses in ACCUM and OUT, result held 10 cycles
      start_job(8);
      for (int i = 0; i < 8; i++) begin
         if (i == 5) begin start = 1'b1; len = LEN_W'(2); end
         send(12'h3C0, 0);
         start = 1'b0;
      end
      finish_job("len8_hold", 8, 12'h480, 10, 1'b1, 0, 8 + ADD_LAT * 3 + 2);

      // Reset after 3 of 8 elements, then a fresh len=2 job
      start_job(8);
      for (int i = 0; i < 3; i++) send(12'h3C0, 0);
      rst_n = 1'b0;
      tick();
      check("midrst_busy", busy_o, 1'b0);
      check("midrst_in_ready", in_ready_o, 1'b0);
      check("midrst_out_valid", out_valid_o, 1'b0);
      check("midrst_out_data", out_data_o, 12'h000);
      check("midrst_add_a", add_a_o, 12'h000);
      check("midrst_add_b", add_b_o, 12'h000);
      rst_n = 1'b1;
      start_job(2);
      send(12'h3C0, 0);
      send(12'h3C0, 0);
      finish_job("after_rst", 2, 12'h400, 0, 1'b0, 0, 1000);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
